// File: rtl/note_player.sv
// note_player: fetches notes one at a time from the pattern source and times them in i_tick units.
// Build option NOTE_PLAYER_REST_EN: a latched pitch of 0 plays as a silent rest.
module note_player #(
   parameter int unsigned TICKS_PER_UNIT = 1,
   parameter int unsigned GAP_TICKS      = 1,
   parameter int unsigned WAIT_TIMEOUT   = 15
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_tick,
   output logic       o_note_stb,
   input  logic       i_note_valid,
   input  logic [5:0] i_note_pitch,
   input  logic [4:0] i_note_len,
   input  logic [3:0] i_note_instrument,
   output logic       o_gate,
   output logic [5:0] o_pitch,
   output logic [3:0] o_instrument,
   output logic       o_note_start,
   output logic       o_timeout
);

   typedef enum logic [1:0] {StIdle, StRequest, StWait, StPlay} state_e;

   state_e      state_q, state_d;
   logic [15:0] remaining_q, remaining_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        tick_seen_q, tick_seen_d;
   logic [5:0]  pitch_q, pitch_d;
   logic [3:0]  instr_q, instr_d;
   logic        start_q, start_d;
   logic        timeout_q, timeout_d;

   logic [5:0]  len_units;
   logic [15:0] note_ticks;
   logic        is_rest;
   logic        incoming_rest;

   // A length field of 0 encodes the longest note, 32 units.
   assign len_units  = (i_note_len == 5'd0) ? 6'd32 : {1'b0, i_note_len};
   assign note_ticks = 16'(32'(len_units) * TICKS_PER_UNIT);

`ifdef NOTE_PLAYER_REST_EN
   assign is_rest       = (pitch_q == 6'd0);
   assign incoming_rest = (i_note_pitch == 6'd0);
`else
   assign is_rest       = 1'b0;
   assign incoming_rest = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      wait_cnt_d  = wait_cnt_q;
      tick_seen_d = tick_seen_q;
      pitch_d     = pitch_q;
      instr_d     = instr_q;
      start_d     = 1'b0;
      timeout_d   = timeout_q;

      if (!i_enable) begin
         timeout_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (i_enable && !timeout_q) begin
               state_d = StRequest;
            end
         end
         StRequest: begin
            state_d    = StWait;
            wait_cnt_d = '0;
         end
         StWait: begin
            if (i_note_valid) begin
               pitch_d     = i_note_pitch;
               instr_d     = i_note_instrument;
               remaining_d = note_ticks;
               tick_seen_d = 1'b0;
               start_d     = !incoming_rest;
               state_d     = StPlay;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
               if (32'(wait_cnt_q) + 32'd1 >= WAIT_TIMEOUT) begin
                  timeout_d = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         StPlay: begin
            if (i_tick) begin
               remaining_d = remaining_q - 16'd1;
               tick_seen_d = 1'b1;
               if (remaining_q == 16'd1) begin
                  state_d = i_enable ? StRequest : StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         wait_cnt_q  <= '0;
         tick_seen_q <= 1'b0;
         pitch_q     <= '0;
         instr_q     <= '0;
         start_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wait_cnt_q  <= wait_cnt_d;
         tick_seen_q <= tick_seen_d;
         pitch_q     <= pitch_d;
         instr_q     <= instr_d;
         start_q     <= start_d;
         timeout_q   <= timeout_d;
      end
   end

   // Gate holds until the first tick so notes shorter than the gap still sound.
   assign o_gate       = (state_q == StPlay) && !is_rest &&
                         (!tick_seen_q || (32'(remaining_q) > GAP_TICKS));
   assign o_note_stb   = (state_q == StRequest);
   assign o_pitch      = pitch_q;
   assign o_instrument = instr_q;
   assign o_note_start = start_q;
   assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed stimulus with a note scoreboard popped on each o_note_start pulse.
// Honours NOTE_PLAYER_REST_EN for the pitch-0 rest case.
module tb_note_player;

   logic       clk = 1'b0;
   logic       rst, en, tick, valid;
   logic [5:0] pitch_in;
   logic [4:0] len_in;
   logic [3:0] instr_in;
   logic       stb, gate, start, tmo;
   logic [5:0] pitch;
   logic [3:0] instr;

   logic       en2, tick2, valid2;
   logic [5:0] pitch_in2;
   logic [4:0] len_in2;
   logic [3:0] instr_in2;
   logic       stb2, gate2, start2, tmo2;
   logic [5:0] pitch2;
   logic [3:0] instr2;

   int vectors = 0;
   int errors  = 0;
   logic [10:0] exp_q[$];
   logic [10:0] exp_e;
   logic        stb_prev = 1'b0;

   always #5 clk = ~clk;

   note_player u_dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_tick(tick), .o_note_stb(stb),
      .i_note_valid(valid), .i_note_pitch(pitch_in), .i_note_len(len_in),
      .i_note_instrument(instr_in), .o_gate(gate), .o_pitch(pitch), .o_instrument(instr),
      .o_note_start(start), .o_timeout(tmo)
   );

   note_player #(.TICKS_PER_UNIT(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_tick(tick2), .o_note_stb(stb2),
      .i_note_valid(valid2), .i_note_pitch(pitch_in2), .i_note_len(len_in2),
      .i_note_instrument(instr_in2), .o_gate(gate2), .o_pitch(pitch2), .o_instrument(instr2),
      .o_note_start(start2), .o_timeout(tmo2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present a note for one clock; the expected latch lands in the scoreboard first.
   task automatic send_note(input logic [5:0] p, input logic [4:0] l, input logic [3:0] i,
                            input logic push, input logic exp_gate);
      if (push) exp_q.push_back({p, i, exp_gate});
      valid    = 1'b1;
      pitch_in = p;
      len_in   = l;
      instr_in = i;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic count_stb(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (stb) n++;
      end
   endtask

   // Monitor: every note start must match the oldest expected note.
   always @(negedge clk) begin
      if (!rst) begin
         if (start) begin
            check("note_start_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               exp_e = exp_q.pop_front();
               check("note_pitch", 32'(pitch), 32'(exp_e[10:5]));
               check("note_instrument", 32'(instr), 32'(exp_e[4:1]));
               check("note_gate", 32'(gate), 32'(exp_e[0]));
            end
         end
         if (stb) check("stb_one_clock_wide", 32'(stb_prev), 32'd0);
      end
      stb_prev <= stb;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; en = 1'b0; tick = 1'b0; valid = 1'b0;
      pitch_in = '0; len_in = '0; instr_in = '0;
      en2 = 1'b0; tick2 = 1'b0; valid2 = 1'b0;
      pitch_in2 = '0; len_in2 = '0; instr_in2 = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({stb, gate, pitch, instr, start, tmo}), 32'd0);
      check("reset_outputs2", 32'({stb2, gate2, pitch2, instr2, start2, tmo2}), 32'd0);

      // First note: request one clock after enable, answer 5 clocks after the strobe.
      rst = 1'b0; en = 1'b1;
      @(negedge clk);
      check("stb_after_enable", 32'(stb), 32'd1);
      @(negedge clk);
      check("stb_low_in_wait", 32'(stb), 32'd0);
      repeat (4) @(negedge clk);
      send_note(6'd12, 5'd3, 4'd2, 1'b1, 1'b1);
      check("gate_first_play", 32'(gate), 32'd1);

      // len=3 with a 1-tick gap.
      do_tick();
      check("gate_after_tick1", 32'(gate), 32'd1);
      do_tick();
      check("gate_after_tick2", 32'(gate), 32'd0);
      check("no_stb_before_tick3", 32'(stb), 32'd0);
      do_tick();
      check("stb_after_tick3", 32'(stb), 32'd1);

      // len=0 means 32 units.
      @(negedge clk);
      send_note(6'd40, 5'd0, 4'd5, 1'b1, 1'b1);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         do_tick();
         n++;
         if (stb) break;
      end
      check("len0_tick_count", 32'(n), 32'd32);

      // Enable dropped mid-note: note completes, nothing more is requested.
      @(negedge clk);
      send_note(6'd7, 5'd2, 4'd9, 1'b1, 1'b1);
      en = 1'b0;
      do_tick();
      do_tick();
      check("no_stb_when_disabled", 32'(stb), 32'd0);
      check("gate_low_after_note", 32'(gate), 32'd0);
      do_tick();
      send_note(6'd63, 5'd1, 4'd15, 1'b0, 1'b0);
      do_tick();
      count_stb(6, n);
      check("idle_no_stb", 32'(n), 32'd0);
      check("idle_pitch_held", 32'(pitch), 32'd7);
      check("idle_instr_held", 32'(instr), 32'd9);

      // Unanswered request times out after 15 waiting clocks.
      en = 1'b1;
      @(negedge clk);
      check("stb_reenable", 32'(stb), 32'd1);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (tmo) break;
         n++;
      end
      check("timeout_wait_clocks", 32'(n), 32'd15);
      check("timeout_set", 32'(tmo), 32'd1);
      count_stb(5, n);
      check("no_stb_after_timeout", 32'(n), 32'd0);
      en = 1'b0;
      @(negedge clk);
      check("timeout_cleared", 32'(tmo), 32'd0);
      en = 1'b1;
      @(negedge clk);
      check("stb_after_clear", 32'(stb), 32'd1);

      // Reset in the middle of a note.
      @(negedge clk);
      send_note(6'd20, 5'd4, 4'd3, 1'b1, 1'b1);
      do_tick();
      rst = 1'b1;
      @(negedge clk);
      check("reset_mid_play", 32'({stb, gate, pitch, instr, start, tmo}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("stb_after_reset", 32'(stb), 32'd1);

      // Pitch 0: silent rest when the option is built in, an ordinary note otherwise.
      @(negedge clk);
`ifdef NOTE_PLAYER_REST_EN
      send_note(6'd0, 5'd2, 4'd1, 1'b0, 1'b0);
      check("rest_gate", 32'(gate), 32'd0);
      check("rest_no_start", 32'(start), 32'd0);
`else
      send_note(6'd0, 5'd2, 4'd1, 1'b1, 1'b1);
      check("pitch0_gate", 32'(gate), 32'd1);
      check("pitch0_start", 32'(start), 32'd1);
`endif
      check("pitch0_latched", 32'(pitch), 32'd0);
      do_tick();
      check("pitch0_no_early_stb", 32'(stb), 32'd0);
      do_tick();
      check("stb_after_pitch0_note", 32'(stb), 32'd1);
      rst = 1'b1; en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // TICKS_PER_UNIT=2, len=4 -> 8 ticks.
      en2 = 1'b1;
      @(negedge clk);
      check("dut2_stb", 32'(stb2), 32'd1);
      @(negedge clk);
      valid2 = 1'b1; pitch_in2 = 6'd33; len_in2 = 5'd4; instr_in2 = 4'd6;
      @(negedge clk);
      valid2 = 1'b0;
      check("dut2_pitch", 32'(pitch2), 32'd33);
      check("dut2_start", 32'(start2), 32'd1);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick2 = 1'b1;
         @(negedge clk);
         tick2 = 1'b0;
         n++;
         if (stb2) break;
      end
      check("dut2_tick_count", 32'(n), 32'd8);
      en2 = 1'b0;

      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
